// File: rtl/filter2d_stream.sv
// 3x3 streaming 2D convolution, one pixel per cycle, two line buffers, zero-padded borders.
// Define FILTER2D_REPLICATE_EN to use edge replication for out-of-frame taps instead.
module filter2d_stream #(
   parameter int unsigned WIDTH  = 256,
   parameter int unsigned HEIGHT = 256,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COEF_W = 8,
   parameter int unsigned SHIFT  = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid,
   output logic              i_ready,
   input  logic              i_sof,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic              o_sof,
   output logic              o_eof,
   output logic [DATA_W-1:0] o_data,
   input  logic              h_write,
   input  logic [3:0]        h_idx,
   input  logic [COEF_W-1:0] h_data
);

   localparam int unsigned XW  = $clog2(WIDTH);
   localparam int unsigned CXW = $clog2(WIDTH + 1);
   localparam int unsigned YW  = $clog2(HEIGHT + 1);
   localparam int unsigned PW  = DATA_W + COEF_W + 1;
   localparam int unsigned SW  = PW + 4;
   localparam logic signed [SW-1:0] RND     = SW'(2 ** (SHIFT - 1));
   localparam logic signed [SW-1:0] PIX_MAX = SW'(2 ** DATA_W - 1);
   localparam int KDEF [9] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

   typedef enum logic [1:0] {S_IDLE, S_ROW, S_PADCOL, S_DRAIN} state_t;

   state_t               state_q, state_d;
   logic [CXW-1:0]       cx_q, cx_d, win_cx;
   logic [YW-1:0]        cy_q, cy_d, win_cy;
   logic                 xfer, step, wr_en, load_kernel;
   logic                 emit, first, last, left_inv, right_inv, top_inv, bot_inv;
   logic [XW-1:0]        addr;
   logic [DATA_W-1:0]    lb0 [WIDTH];
   logic [DATA_W-1:0]    lb1 [WIDTH];
   logic [DATA_W-1:0]    col_new [3];
   logic [DATA_W-1:0]    w1_q [3];
   logic [DATA_W-1:0]    w2_q [3];
   logic [DATA_W-1:0]    tc [9];
   logic [DATA_W-1:0]    tap [9];
   logic signed [COEF_W-1:0] stg_q [9];
   logic signed [COEF_W-1:0] act_q [9];
   logic signed [PW-1:0] prod_q [9];
   logic signed [SW-1:0] sum_c, sum_q, rnd_c;
   logic [DATA_W-1:0]    pix_c;
   logic                 s1_valid, s1_sof, s1_eof, s2_valid, s2_sof, s2_eof;

   assign xfer = i_valid & i_ready;

   // Raster walker: (win_cx, win_cy) is the position this cycle's transfer or pad step fills
   always_comb begin
      state_d     = state_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      win_cx      = cx_q;
      win_cy      = cy_q;
      step        = 1'b0;
      wr_en       = 1'b0;
      load_kernel = 1'b0;
      case (state_q)
         S_IDLE, S_ROW: begin
            if (xfer && i_sof) begin
               state_d     = S_ROW;
               cx_d        = CXW'(1);
               cy_d        = '0;
               win_cx      = '0;
               win_cy      = '0;
               step        = 1'b1;
               wr_en       = 1'b1;
               load_kernel = 1'b1;
            end else if (xfer && state_q == S_ROW) begin
               step  = 1'b1;
               wr_en = 1'b1;
               if (cx_q == CXW'(WIDTH - 1)) begin
                  state_d = S_PADCOL;
                  cx_d    = CXW'(WIDTH);
               end else begin
                  cx_d = cx_q + CXW'(1);
               end
            end
         end
         S_PADCOL: begin
            step = 1'b1;
            cx_d = '0;
            if (cy_q == YW'(HEIGHT - 1)) begin
               state_d = S_DRAIN;
               cy_d    = YW'(HEIGHT);
            end else begin
               state_d = S_ROW;
               cy_d    = cy_q + YW'(1);
            end
         end
         S_DRAIN: begin
            step = 1'b1;
            if (cx_q == CXW'(WIDTH)) begin
               state_d = S_IDLE;
               cx_d    = '0;
               cy_d    = '0;
            end else begin
               cx_d = cx_q + CXW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cx_q    <= '0;
         cy_q    <= '0;
         i_ready <= 1'b0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         i_ready <= (state_d == S_IDLE) || (state_d == S_ROW);
      end
   end

   always_comb begin
      emit      = step && (win_cx != '0) && (win_cy != '0);
      first     = (win_cx == CXW'(1)) && (win_cy == YW'(1));
      last      = (win_cx == CXW'(WIDTH)) && (win_cy == YW'(HEIGHT));
      left_inv  = (win_cx == CXW'(1));
      right_inv = (win_cx == CXW'(WIDTH));
      top_inv   = (win_cy == YW'(1));
      bot_inv   = (win_cy == YW'(HEIGHT));
      addr      = (win_cx >= CXW'(WIDTH)) ? '0 : XW'(win_cx);
   end

   // Newest column: two buffered rows above plus the incoming pixel
   always_comb begin
      col_new[0] = lb1[addr];
      col_new[1] = lb0[addr];
      col_new[2] = i_data;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         lb1[addr] <= lb0[addr];
         lb0[addr] <= i_data;
      end
      if (step) begin
         for (int r = 0; r < 3; r++) begin
            w2_q[r] <= w1_q[r];
            w1_q[r] <= col_new[r];
         end
      end
   end

   // Column border handling first, then rows, so corners pick up the corner pixel
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         tc[r*3]   = w2_q[r];
         tc[r*3+1] = w1_q[r];
         tc[r*3+2] = col_new[r];
`ifdef FILTER2D_REPLICATE_EN
         if (left_inv)  tc[r*3]   = w1_q[r];
         if (right_inv) tc[r*3+2] = w1_q[r];
`else
         if (left_inv)  tc[r*3]   = '0;
         if (right_inv) tc[r*3+2] = '0;
`endif
      end
   end

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         tap[c]   = tc[c];
         tap[3+c] = tc[3+c];
         tap[6+c] = tc[6+c];
`ifdef FILTER2D_REPLICATE_EN
         if (top_inv) tap[c]   = tc[3+c];
         if (bot_inv) tap[6+c] = tc[3+c];
`else
         if (top_inv) tap[c]   = '0;
         if (bot_inv) tap[6+c] = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 9; k++) begin
            stg_q[k] <= COEF_W'(KDEF[k]);
            act_q[k] <= COEF_W'(KDEF[k]);
         end
      end else begin
         if (h_write && h_idx < 4'd9) stg_q[h_idx] <= h_data;
         if (load_kernel) act_q <= stg_q;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 9; k++)
         prod_q[k] <= PW'($signed({1'b0, tap[k]})) * PW'(act_q[k]);
      sum_q <= sum_c;
   end

   always_comb begin
      sum_c = '0;
      for (int k = 0; k < 9; k++) sum_c = sum_c + SW'(prod_q[k]);
   end

   always_comb begin
      rnd_c = (sum_q + RND) >>> SHIFT;
      if (rnd_c[SW-1])           pix_c = '0;
      else if (rnd_c > PIX_MAX)  pix_c = '1;
      else                       pix_c = DATA_W'(rnd_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_eof   <= 1'b0;
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
         s2_eof   <= 1'b0;
         o_valid  <= 1'b0;
         o_sof    <= 1'b0;
         o_eof    <= 1'b0;
         o_data   <= '0;
      end else begin
         s1_valid <= emit;
         s1_sof   <= emit & first;
         s1_eof   <= emit & last;
         s2_valid <= s1_valid;
         s2_sof   <= s1_sof;
         s2_eof   <= s1_eof;
         o_valid  <= s2_valid;
         o_sof    <= s2_sof;
         o_eof    <= s2_eof;
         if (s2_valid) o_data <= pix_c;
      end
   end

endmodule

// File: tb/tb_filter2d_stream.sv
// Directed bench for filter2d_stream on an 8x4 frame; expected pixels are hand-derived constants.
module tb_filter2d_stream;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int DW   = 8;
   localparam int CWID = 9;
   localparam int SH   = 7;
   localparam int N    = W * H;

   typedef logic [31:0] w32_t;
   typedef int kern_t [9];

   logic            clk = 1'b0;
   logic            reset, i_valid, i_ready, i_sof;
   logic [DW-1:0]   i_data;
   logic            o_valid, o_sof, o_eof;
   logic [DW-1:0]   o_data;
   logic            h_write;
   logic [3:0]      h_idx;
   logic [CWID-1:0] h_data;

   int   total, bad, cyc;
   logic rdy_s;
   w32_t q_data[$];
   w32_t q_sof[$];
   w32_t q_eof[$];
   int   q_cyc[$];
   int   xfer_cyc [N];

   kern_t K_DEF = '{8, 16, 8, 16, 32, 16, 8, 16, 8};
   kern_t K_ID  = '{0, 0, 0, 0, 128, 0, 0, 0, 0};
   kern_t K_NEG = '{0, 0, 0, 0, -128, 0, 0, 0, 0};
   kern_t K_ALL = '{127, 127, 127, 127, 127, 127, 127, 127, 127};

   always #5 clk = ~clk;

   filter2d_stream #(
      .WIDTH(W), .HEIGHT(H), .DATA_W(DW), .COEF_W(CWID), .SHIFT(SH)
   ) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_ready(i_ready), .i_sof(i_sof), .i_data(i_data),
      .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof), .o_data(o_data),
      .h_write(h_write), .h_idx(h_idx), .h_data(h_data)
   );

   task automatic check(input string tag, input w32_t got, input w32_t want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
      end
   endtask

   // One clock: sample outputs on the falling edge, then step past the rising edge
   task automatic cycle();
      @(negedge clk);
      rdy_s = i_ready;
      if (o_valid === 1'b1) begin
         q_data.push_back(w32_t'(o_data));
         q_sof.push_back(w32_t'(o_sof));
         q_eof.push_back(w32_t'(o_eof));
         q_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_q();
      q_data.delete();
      q_sof.delete();
      q_eof.delete();
      q_cyc.delete();
   endtask

   task automatic send_pixel(input logic [DW-1:0] d, input logic sof, output int xc);
      int n;
      n = 0;
      xc = -1;
      i_valid = 1'b1;
      i_data  = d;
      i_sof   = sof;
      while (xc < 0 && n < 50) begin
         cycle();
         if (rdy_s === 1'b1) xc = cyc - 1;
         n++;
      end
      i_valid = 1'b0;
      i_sof   = 1'b0;
      if (xc < 0) begin
         total++;
         bad++;
         $error("FAIL ready_timeout: observed=no_ready expected=ready");
      end
   endtask

   task automatic write_coef(input int idx, input int v);
      h_write = 1'b1;
      h_idx   = 4'(idx);
      h_data  = CWID'(v);
      cycle();
      h_write = 1'b0;
   endtask

   task automatic write_kernel(input kern_t k);
      for (int i = 0; i < 9; i++) write_coef(i, k[i]);
      write_coef(12, 77);
   endtask

   // kind 1 = ramp (value = raster index), otherwise constant val
   task automatic send_frame(input int kind, input int val, input int kw_at,
                             input bit bubbles, input kern_t kw);
      int xc;
      int idx;
      logic [DW-1:0] d;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            idx = y * W + x;
            if (idx == kw_at) write_kernel(kw);
            d = (kind == 1) ? DW'(idx) : DW'(val);
            send_pixel(d, idx == 0, xc);
            xfer_cyc[idx] = xc;
            if (bubbles && (idx % 5 == 3)) cycle();
         end
      end
      repeat (W + 12) cycle();
   endtask

   // 0: default kernel on flat 100, 1: identity of ramp, 2: all 0, 3: all 255
   function automatic int exp_val(input int kind, input int idx);
      int x, y, nb;
      x = idx % W;
      y = idx / W;
      nb = int'(x == 0 || x == W - 1) + int'(y == 0 || y == H - 1);
      case (kind)
`ifdef FILTER2D_REPLICATE_EN
         0: return 100;
`else
         0: return (nb == 2) ? 56 : (nb == 1) ? 75 : 100;
`endif
         1: return idx;
         2: return 0;
         default: return 255;
      endcase
   endfunction

   task automatic check_frame(input string tag, input int kind);
      check($sformatf("%s_count", tag), w32_t'(q_data.size()), w32_t'(N));
      for (int i = 0; i < q_data.size() && i < N; i++) begin
         check($sformatf("%s_data[%0d]", tag, i), q_data[i], w32_t'(exp_val(kind, i)));
         check($sformatf("%s_sof[%0d]", tag, i), q_sof[i], w32_t'(i == 0));
         check($sformatf("%s_eof[%0d]", tag, i), q_eof[i], w32_t'(i == N - 1));
      end
   endtask

   initial begin
      int xc, n_sof, n_eof;
      total = 0; bad = 0; cyc = 0;
      reset = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_data = '0;
      h_write = 1'b0; h_idx = '0; h_data = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", w32_t'(i_ready), 0);
      check("rst_valid", w32_t'(o_valid), 0);
      check("rst_data", w32_t'(o_data), 0);
      check("rst_sof", w32_t'(o_sof), 0);
      check("rst_eof", w32_t'(o_eof), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_ready_up", w32_t'(i_ready), 1);
      @(posedge clk);
      #1;

      // default kernel on a flat frame
      clear_q();
      send_frame(0, 100, -1, 1'b0, K_DEF);
      check_frame("t1", 0);

      // identity kernel on a ramp with input bubbles; window-to-output latency
      write_kernel(K_ID);
      clear_q();
      send_frame(1, 0, -1, 1'b1, K_ID);
      check_frame("t2", 1);
      if (q_cyc.size() > W + 1) begin
         check("t2_lat_first", w32_t'(q_cyc[0] - xfer_cyc[W + 1]), 3);
         check("t2_lat_mid", w32_t'(q_cyc[W + 1] - xfer_cyc[2 * W + 2]), 3);
      end

      // clamping at both ends
      write_kernel(K_NEG);
      clear_q();
      send_frame(1, 0, -1, 1'b0, K_ID);
      check_frame("t4_neg", 2);
      write_kernel(K_ALL);
      clear_q();
      send_frame(0, 255, -1, 1'b0, K_ID);
      check_frame("t4_sat", 3);

      // mid-frame kernel write takes effect only at the next frame
      write_kernel(K_ID);
      clear_q();
      send_frame(1, 0, 13, 1'b0, K_DEF);
      check_frame("t5_old", 1);
      clear_q();
      send_frame(0, 100, -1, 1'b0, K_DEF);
      check_frame("t5_new", 0);

      // restart at (3,2), then reset during drain
      clear_q();
      for (int i = 0; i < 2 * W + 3; i++) send_pixel(DW'(100), i == 0, xc);
      for (int i = 0; i < N; i++) send_pixel(DW'(100), i == 0, xc);
      repeat (4) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      @(negedge clk);
      check("t6_valid_after_rst", w32_t'(o_valid), 0);
      @(posedge clk);
      #1;
      n_sof = 0;
      n_eof = 0;
      foreach (q_sof[i]) if (q_sof[i] === 32'd1) n_sof++;
      foreach (q_eof[i]) if (q_eof[i] === 32'd1) n_eof++;
      check("t6_sof_count", w32_t'(n_sof), 2);
      check("t6_eof_count", w32_t'(n_eof), 0);
      clear_q();
      send_frame(0, 100, -1, 1'b0, K_DEF);
      check_frame("t6_clean", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
